// File: rtl/prn_pkg.sv
// Shared constants and types for the PRN chip generator.
package prn_pkg;

    localparam logic [9:0] TAPS0_DEFAULT = 10'h204;
    localparam logic [9:0] TAPS1_DEFAULT = 10'h3A6;

    typedef enum logic {
        IDLE,
        RUN
    } prn_state_e;

endpackage

// File: rtl/prn_chip_gen_lfsr.sv
// Fibonacci LFSR stage chain: parallel load, shift toward stage W, or hold.
module prn_lfsr #(
    parameter int unsigned  W    = 10,
    parameter logic [W-1:0] TAPS = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] seed_i,
    output logic         out_o
);

    logic [W-1:0] r_q, r_d;

    // Bit k holds stage k+1; the feedback enters stage 1.
    always_comb begin
        r_d = r_q;
        if (load_i) begin
            r_d = seed_i;
        end else if (shift_i) begin
            r_d = {r_q[W-2:0], ^(r_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign out_o = r_q[W-1];

endmodule

// File: rtl/prn_chip_gen.sv
// Serial PRN chip generator: two LFSRs XORed per chip, epoch-aligned seed reload,
// first/last chip capture per code period.
module prn_chip_gen
    import prn_pkg::*;
#(
    parameter int unsigned  W        = 10,
    parameter logic [W-1:0] TAPS0    = TAPS0_DEFAULT,
    parameter logic [W-1:0] TAPS1    = TAPS1_DEFAULT,
    parameter int unsigned  CODE_LEN = 1023,
    parameter int unsigned  FIRST_N  = 24,
    localparam int unsigned CW       = $clog2(CODE_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_valid,
    output logic               seed_ready,
    input  logic [W-1:0]       seed_r0,
    input  logic [W-1:0]       seed_r1,
    input  logic               chip_en,
    input  logic               abort,
    output logic               chip,
    output logic               chip_valid,
    output logic [CW-1:0]      chip_idx,
    output logic               epoch,
    output logic               code_done,
    output logic [FIRST_N-1:0] first_chips,
    output logic [FIRST_N-1:0] last_chips,
    output logic               seed_err
);

    localparam logic [CW-1:0] LAST_IDX  = CW'(CODE_LEN - 1);
    localparam logic [CW-1:0] FIRST_IDX = CW'(FIRST_N - 1);

    prn_state_e         state_q, state_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic [W-1:0]       act0_q, act0_d, act1_q, act1_d;
    logic [W-1:0]       pend0_q, pend0_d, pend1_q, pend1_d;
    logic               pend_v_q, pend_v_d;
    logic [FIRST_N-1:0] first_q, first_d, last_q, last_d, cap;
    logic               seed_err_q, code_done_q;
    logic               accept, seed_ok, advance, at_end, wrap;
    logic               lfsr_load, lfsr_shift;
    logic [W-1:0]       load0, load1;
    logic               r0_out, r1_out;

    assign seed_ready = !abort && ((state_q == IDLE) || !pend_v_q);
    assign accept     = seed_valid && seed_ready;
    assign seed_ok    = (seed_r0 != '0) && (seed_r1 != '0);
    assign chip       = r0_out ^ r1_out;
    assign chip_valid = (state_q == RUN) && chip_en;
    assign advance    = chip_valid && !abort;
    assign at_end     = (idx_q == LAST_IDX);
    assign epoch      = chip_valid && at_end;
    assign wrap       = advance && at_end;

    // Capture window always includes the chip being emitted this cycle.
    if (FIRST_N > 1) begin : g_shadow
        logic [FIRST_N-2:0] shadow_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
            end else if (advance) begin
                shadow_q <= cap[FIRST_N-2:0];
            end
        end
        assign cap = {shadow_q, chip};
    end else begin : g_no_shadow
        assign cap = chip;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        act0_d     = act0_q;
        act1_d     = act1_q;
        pend0_d    = pend0_q;
        pend1_d    = pend1_q;
        pend_v_d   = pend_v_q;
        first_d    = first_q;
        last_d     = last_q;
        lfsr_load  = 1'b0;
        lfsr_shift = 1'b0;
        load0      = act0_q;
        load1      = act1_q;
        case (state_q)
            IDLE: begin
                if (accept && seed_ok) begin
                    lfsr_load = 1'b1;
                    load0     = seed_r0;
                    load1     = seed_r1;
                    act0_d    = seed_r0;
                    act1_d    = seed_r1;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    pend_v_d = 1'b0;
                end else begin
                    if (accept && seed_ok) begin
                        pend0_d  = seed_r0;
                        pend1_d  = seed_r1;
                        pend_v_d = 1'b1;
                    end
                    if (advance) begin
                        if (idx_q == FIRST_IDX) begin
                            first_d = cap;
                        end
                        if (at_end) begin
                            // Wrap reloads instead of shifting; a pending seed wins over the active one.
                            last_d    = cap;
                            idx_d     = '0;
                            lfsr_load = 1'b1;
                            if (pend_v_q) begin
                                load0    = pend0_q;
                                load1    = pend1_q;
                                act0_d   = pend0_q;
                                act1_d   = pend1_q;
                                pend_v_d = 1'b0;
                            end
                        end else begin
                            lfsr_shift = 1'b1;
                            idx_d      = idx_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            act0_q      <= '0;
            act1_q      <= '0;
            pend0_q     <= '0;
            pend1_q     <= '0;
            pend_v_q    <= 1'b0;
            first_q     <= '0;
            last_q      <= '0;
            seed_err_q  <= 1'b0;
            code_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act0_q      <= act0_d;
            act1_q      <= act1_d;
            pend0_q     <= pend0_d;
            pend1_q     <= pend1_d;
            pend_v_q    <= pend_v_d;
            first_q     <= first_d;
            last_q      <= last_d;
            seed_err_q  <= accept && !seed_ok;
            code_done_q <= wrap;
        end
    end

    prn_lfsr #(.W(W), .TAPS(TAPS0)) u_r0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .shift_i (lfsr_shift),
        .seed_i  (load0),
        .out_o   (r0_out)
    );

    prn_lfsr #(.W(W), .TAPS(TAPS1)) u_r1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .shift_i (lfsr_shift),
        .seed_i  (load1),
        .out_o   (r1_out)
    );

    assign chip_idx    = idx_q;
    assign first_chips = first_q;
    assign last_chips  = last_q;
    assign code_done   = code_done_q;
    assign seed_err    = seed_err_q;

endmodule

// File: tb/tb_prn_chip_gen.sv
// Bench for prn_chip_gen: full-length default code plus a short-code instance
// driven with randomized chip_en/seed/abort against a period-level reference.
module tb_prn_chip_gen;

    localparam int unsigned LEN_A = 1023;
    localparam int unsigned FN_A  = 24;
    localparam int unsigned LEN_B = 8;
    localparam int unsigned FN_B  = 3;
    localparam logic [9:0]  TAPS_R0 = 10'h204;
    localparam logic [9:0]  TAPS_R1 = 10'h3A6;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_rst_n, a_seed_valid, a_seed_ready, a_chip_en, a_abort;
    logic            a_chip, a_chip_valid, a_epoch, a_code_done, a_seed_err;
    logic [9:0]      a_seed_r0, a_seed_r1, a_chip_idx;
    logic [FN_A-1:0] a_first, a_last;

    logic            b_rst_n, b_seed_valid, b_seed_ready, b_chip_en, b_abort;
    logic            b_chip, b_chip_valid, b_epoch, b_code_done, b_seed_err;
    logic [9:0]      b_seed_r0, b_seed_r1;
    logic [2:0]      b_chip_idx;
    logic [FN_B-1:0] b_first, b_last;

    prn_chip_gen #(.W(10), .TAPS0(TAPS_R0), .TAPS1(TAPS_R1), .CODE_LEN(LEN_A), .FIRST_N(FN_A)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
        .seed_r0(a_seed_r0), .seed_r1(a_seed_r1), .chip_en(a_chip_en), .abort(a_abort),
        .chip(a_chip), .chip_valid(a_chip_valid), .chip_idx(a_chip_idx), .epoch(a_epoch),
        .code_done(a_code_done), .first_chips(a_first), .last_chips(a_last), .seed_err(a_seed_err)
    );

    prn_chip_gen #(.W(10), .TAPS0(TAPS_R0), .TAPS1(TAPS_R1), .CODE_LEN(LEN_B), .FIRST_N(FN_B)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
        .seed_r0(b_seed_r0), .seed_r1(b_seed_r1), .chip_en(b_chip_en), .abort(b_abort),
        .chip(b_chip), .chip_valid(b_chip_valid), .chip_idx(b_chip_idx), .epoch(b_epoch),
        .code_done(b_code_done), .first_chips(b_first), .last_chips(b_last), .seed_err(b_seed_err)
    );

    // Reference code: stage k+1 held in bit k, stage 1 takes the XOR of tapped stages.
    bit              code_ref[LEN_A];
    logic [FN_A-1:0] exp_first_a, exp_last_a;

    function automatic logic [9:0] stage_shift(input logic [9:0] r, input logic [9:0] taps);
        logic fb;
        fb = 1'b0;
        for (int k = 0; k < 10; k++) if (taps[k]) fb ^= r[k];
        return {r[8:0], fb};
    endfunction

    function automatic bit ref_chip(input logic [9:0] s0, input logic [9:0] s1, input int unsigned n);
        logic [9:0] r0, r1;
        r0 = s0;
        r1 = s1;
        for (int unsigned t = 0; t < n; t++) begin
            r0 = stage_shift(r0, TAPS_R0);
            r1 = stage_shift(r1, TAPS_R1);
        end
        return r0[9] ^ r1[9];
    endfunction

    task automatic gen_code(input logic [9:0] s0, input logic [9:0] s1);
        logic [9:0] r0, r1;
        r0 = s0;
        r1 = s1;
        for (int unsigned i = 0; i < LEN_A; i++) begin
            code_ref[i] = r0[9] ^ r1[9];
            r0 = stage_shift(r0, TAPS_R0);
            r1 = stage_shift(r1, TAPS_R1);
        end
        for (int unsigned i = 0; i < FN_A; i++) begin
            exp_first_a[FN_A-1-i] = code_ref[i];
            exp_last_a[FN_A-1-i]  = code_ref[LEN_A-FN_A+i];
        end
    endtask

    function automatic logic [19:0] rand_pair(input bit allow_zero);
        logic [9:0] r0, r1;
        r0 = 10'($urandom_range(1, 1023));
        r1 = 10'($urandom_range(1, 1023));
        if (allow_zero && ($urandom % 4 == 0)) begin
            if ($urandom % 2 == 0) r0 = '0;
            else r1 = '0;
        end
        return {r0, r1};
    endfunction

    // Short-code reference: period/seed level state of instance B.
    bit              m_run, m_pv, m_err, m_done, m_acc;
    logic [9:0]      m_c0, m_c1, m_p0, m_p1;
    int unsigned     m_idx;
    logic [FN_B-1:0] m_first, m_last;

    task automatic model_edge();
        bit rdy, acc, zero, adv;
        rdy    = !b_abort && (!m_run || !m_pv);
        acc    = b_seed_valid && rdy;
        zero   = (b_seed_r0 == 10'd0) || (b_seed_r1 == 10'd0);
        adv    = m_run && b_chip_en && !b_abort;
        m_acc  = acc;
        m_err  = acc && zero;
        m_done = adv && (m_idx == LEN_B - 1);
        if (!m_run) begin
            if (acc && !zero) begin
                m_run = 1'b1; m_c0 = b_seed_r0; m_c1 = b_seed_r1; m_idx = 0;
            end
        end else if (b_abort) begin
            m_run = 1'b0; m_idx = 0; m_pv = 1'b0;
        end else begin
            if (adv) begin
                if (m_idx == FN_B - 1)
                    for (int unsigned j = 0; j < FN_B; j++) m_first[FN_B-1-j] = ref_chip(m_c0, m_c1, j);
                if (m_idx == LEN_B - 1) begin
                    for (int unsigned j = 0; j < FN_B; j++)
                        m_last[FN_B-1-j] = ref_chip(m_c0, m_c1, LEN_B - FN_B + j);
                    m_idx = 0;
                    if (m_pv) begin
                        m_c0 = m_p0; m_c1 = m_p1; m_pv = 1'b0;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (acc && !zero) begin
                m_p0 = b_seed_r0; m_p1 = b_seed_r1; m_pv = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; a_seed_valid = 1'b0; a_chip_en = 1'b0; a_abort = 1'b0; a_seed_r0 = '0; a_seed_r1 = '0;
        b_rst_n = 1'b0; b_seed_valid = 1'b0; b_chip_en = 1'b0; b_abort = 1'b0; b_seed_r0 = '0; b_seed_r1 = '0;
        #2;
        n_tests++;
        if ({b_seed_ready, b_chip_valid, b_chip, b_code_done, b_seed_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_b_flags got %b expected 10000",
                     {b_seed_ready, b_chip_valid, b_chip, b_code_done, b_seed_err});
        end
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_tests++;
            if ({a_seed_ready, a_chip_valid, a_chip, a_epoch, a_code_done, a_seed_err} !== 6'b100000) begin
                n_fail++;
                $display("FAIL idle_flags cyc=%0d got %b expected 100000", i,
                         {a_seed_ready, a_chip_valid, a_chip, a_epoch, a_code_done, a_seed_err});
            end
            n_tests++;
            if (a_chip_idx !== 10'd0 || a_first !== '0 || a_last !== '0) begin
                n_fail++;
                $display("FAIL idle_regs cyc=%0d got idx=%0d first=%h last=%h expected 0/0/0",
                         i, a_chip_idx, a_first, a_last);
            end
        end
    endtask

    task automatic test_full_period();
        gen_code(10'h3FF, 10'h001);
        @(posedge clk);
        #1;
        a_seed_r0 = 10'h3FF; a_seed_r1 = 10'h001; a_seed_valid = 1'b1; a_chip_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_seed_ready !== 1'b1 || a_chip_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle got ready=%b valid=%b expected 1/0", a_seed_ready, a_chip_valid);
        end
        @(posedge clk);
        #1;
        a_seed_valid = 1'b0;
        for (int i = 0; i < int'(LEN_A); i++) begin
            @(negedge clk);
            n_tests++;
            if (a_chip_valid !== 1'b1 || a_chip_idx !== 10'(i) || a_chip !== code_ref[i]) begin
                n_fail++;
                $display("FAIL full_chip i=%0d got valid=%b idx=%0d chip=%b expected 1/%0d/%b",
                         i, a_chip_valid, a_chip_idx, a_chip, i, code_ref[i]);
            end
            n_tests++;
            if (a_epoch !== (i == int'(LEN_A) - 1) || a_code_done !== 1'b0) begin
                n_fail++;
                $display("FAIL full_epoch i=%0d got epoch=%b done=%b expected %b/0",
                         i, a_epoch, a_code_done, i == int'(LEN_A) - 1);
            end
            if (i == 0) begin
                n_tests++;
                if (a_chip !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_chip got %b expected 1", a_chip);
                end
            end
            if (i == int'(FN_A) - 1 || i == int'(FN_A)) begin
                n_tests++;
                if (a_first !== ((i == int'(FN_A)) ? exp_first_a : '0)) begin
                    n_fail++;
                    $display("FAIL first_capture_timing i=%0d got %h expected %h", i, a_first,
                             (i == int'(FN_A)) ? exp_first_a : '0);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (a_code_done !== 1'b1 || a_chip_idx !== 10'd0 || a_chip !== code_ref[0]) begin
            n_fail++;
            $display("FAIL code_done got done=%b idx=%0d chip=%b expected 1/0/%b",
                     a_code_done, a_chip_idx, a_chip, code_ref[0]);
        end
        n_tests++;
        if (a_first !== exp_first_a || a_last !== exp_last_a) begin
            n_fail++;
            $display("FAIL capture got first=%h last=%h expected %h/%h", a_first, a_last, exp_first_a, exp_last_a);
        end
        @(negedge clk);
        n_tests++;
        if (a_code_done !== 1'b0 || a_chip_idx !== 10'd1 || a_chip !== code_ref[1]) begin
            n_fail++;
            $display("FAIL second_period got done=%b idx=%0d chip=%b expected 0/1/%b",
                     a_code_done, a_chip_idx, a_chip, code_ref[1]);
        end
    endtask

    task automatic test_abort();
        for (int i = 1; i < 499; i++) @(negedge clk);
        @(posedge clk);
        #1;
        a_abort = 1'b1; a_seed_valid = 1'b1; a_seed_r0 = 10'h0F0; a_seed_r1 = 10'h10F;
        @(negedge clk);
        n_tests++;
        if (a_chip_idx !== 10'd500 || a_seed_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle got idx=%0d ready=%b expected 500/0", a_chip_idx, a_seed_ready);
        end
        @(posedge clk);
        #1;
        a_abort = 1'b0; a_seed_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({a_chip_valid, a_code_done, a_seed_ready} !== 3'b001 || a_chip_idx !== 10'd0) begin
            n_fail++;
            $display("FAIL abort_idle got valid=%b done=%b ready=%b idx=%0d expected 0/0/1/0",
                     a_chip_valid, a_code_done, a_seed_ready, a_chip_idx);
        end
        n_tests++;
        if (a_last !== exp_last_a) begin
            n_fail++;
            $display("FAIL abort_last_kept got %h expected %h", a_last, exp_last_a);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_chip_valid !== 1'b0 || a_code_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_seed_dropped cyc=%0d got valid=%b done=%b expected 0/0",
                         i, a_chip_valid, a_code_done);
            end
        end
    endtask

    task automatic test_async_reset();
        gen_code(10'h155, 10'h2AA);
        @(posedge clk);
        #1;
        a_seed_r0 = 10'h155; a_seed_r1 = 10'h2AA; a_seed_valid = 1'b1; a_chip_en = 1'b1;
        @(posedge clk);
        #1;
        a_seed_valid = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (a_chip_valid !== 1'b1 || a_chip_idx !== 10'd29 || a_first !== exp_first_a) begin
            n_fail++;
            $display("FAIL pre_reset got valid=%b idx=%0d first=%h expected 1/29/%h",
                     a_chip_valid, a_chip_idx, a_first, exp_first_a);
        end
        #2;
        a_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_seed_ready, a_chip_valid, a_chip, a_epoch, a_code_done, a_seed_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL async_reset_flags got %b expected 100000",
                     {a_seed_ready, a_chip_valid, a_chip, a_epoch, a_code_done, a_seed_err});
        end
        n_tests++;
        if (a_chip_idx !== 10'd0 || a_first !== '0 || a_last !== '0) begin
            n_fail++;
            $display("FAIL async_reset_regs got idx=%0d first=%h last=%h expected 0/0/0", a_chip_idx, a_first, a_last);
        end
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_seed_ready !== 1'b1 || a_chip_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got ready=%b valid=%b expected 1/0", a_seed_ready, a_chip_valid);
        end
        a_chip_en = 1'b0;
    endtask

    // Phases: 50% chip_en, pending seed pair, zero seed, then random en/seed/abort mix.
    task automatic test_short_code();
        logic [19:0] seed_q[$];
        bit          exp_chip;
        m_run = 0; m_pv = 0; m_err = 0; m_done = 0; m_acc = 0; m_idx = 0;
        m_c0 = '0; m_c1 = '0; m_p0 = '0; m_p1 = '0; m_first = '0; m_last = '0;
        for (int c = 0; c < 320; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            if (m_acc && seed_q.size() > 0) void'(seed_q.pop_front());
            if (c == 0) seed_q.push_back(rand_pair(1'b0));
            if (c == 60) begin
                seed_q.push_back(rand_pair(1'b0));
                seed_q.push_back(rand_pair(1'b0));
            end
            if (c == 100) seed_q.push_back({10'd0, 10'($urandom_range(1, 1023))});
            b_abort = 1'b0;
            if (c < 60) begin
                b_chip_en = 1'($urandom_range(0, 1));
            end else if (c < 120) begin
                b_chip_en = 1'b1;
            end else if (c < 300) begin
                b_chip_en = ($urandom % 10) < 7;
                b_abort   = ($urandom % 30) == 0;
                if (seed_q.size() == 0 && ($urandom % 10) == 0) seed_q.push_back(rand_pair(1'b1));
            end else begin
                b_chip_en = 1'b0;
            end
            b_seed_valid = seed_q.size() > 0;
            {b_seed_r0, b_seed_r1} = (seed_q.size() > 0) ? seed_q[0] : 20'd0;
            @(negedge clk);
            n_tests++;
            if (b_seed_ready !== (!b_abort && (!m_run || !m_pv))) begin
                n_fail++;
                $display("FAIL short_ready c=%0d got %b expected %b", c, b_seed_ready, !b_abort && (!m_run || !m_pv));
            end
            n_tests++;
            if (b_chip_valid !== (m_run && b_chip_en) || b_chip_idx !== 3'(m_idx)
                || b_epoch !== (m_run && b_chip_en && m_idx == LEN_B - 1)) begin
                n_fail++;
                $display("FAIL short_stream c=%0d got valid=%b idx=%0d epoch=%b expected %b/%0d/%b", c,
                         b_chip_valid, b_chip_idx, b_epoch, m_run && b_chip_en, m_idx,
                         m_run && b_chip_en && m_idx == LEN_B - 1);
            end
            if (m_run) begin
                exp_chip = ref_chip(m_c0, m_c1, m_idx);
                n_tests++;
                if (b_chip !== exp_chip) begin
                    n_fail++;
                    $display("FAIL short_chip c=%0d idx=%0d got %b expected %b", c, m_idx, b_chip, exp_chip);
                end
            end
            n_tests++;
            if (b_code_done !== m_done || b_seed_err !== m_err) begin
                n_fail++;
                $display("FAIL short_pulses c=%0d got done=%b err=%b expected %b/%b",
                         c, b_code_done, b_seed_err, m_done, m_err);
            end
            n_tests++;
            if (b_first !== m_first || b_last !== m_last) begin
                n_fail++;
                $display("FAIL short_capture c=%0d got first=%b last=%b expected %b/%b",
                         c, b_first, b_last, m_first, m_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_abort();
        test_async_reset();
        test_short_code();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
